// File: rtl/alu_result_display_if.sv
// Handshake bundle between the 4-bit ALU and its result display stage.
interface alu_result_display_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_signed;

    modport master (
        output in_valid,
        output in_data,
        output in_signed,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_signed,
        output in_ready
    );
endinterface

// File: rtl/alu_result_display.sv
// ALU result display: captures an 8-bit result, converts it to BCD with a
// sequential double-dabble (one step per enabled cycle), then scans
// sign/hundreds/tens/ones/blank frames onto one 7-segment display.
// Optional feature macro: ALU_DISP_LZB_EN (leading-zero blanking).
module alu_result_display #(
    parameter int unsigned DIGIT_TICKS = 2500000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    alu_result_display_if.slave        bus,
    output logic [6:0]                 seg,
    output logic                       dp,
    output logic [2:0]                 frame
);

    localparam int unsigned TickW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(DIGIT_TICKS - 1);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StConvert = 2'd1;
    localparam logic [1:0] StShow    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [2:0]       frame_q, frame_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [11:0]      bcd_q, bcd_d;
    logic [7:0]       mag_q, mag_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             accept;
    logic [11:0]      bcd_adj;

    function automatic logic [3:0] dd_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign bus.in_ready = (state_q != StConvert);
    assign accept       = bus.in_valid & bus.in_ready & ena;
    assign bcd_adj      = {dd_adj(bcd_q[11:8]), dd_adj(bcd_q[7:4]), dd_adj(bcd_q[3:0])};

    // Next-state: capture, double-dabble steps, frame scanning; everything holds when ena is low
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        tick_d  = tick_q;
        bcd_d   = bcd_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        if (accept) begin
            neg_d   = bus.in_signed & bus.in_data[7];
            // 8-bit negate is enough: -8'h80 wraps to 8'h80, which reads as 128 unsigned
            mag_d   = neg_d ? (8'd0 - bus.in_data) : bus.in_data;
            bcd_d   = 12'd0;
            cnt_d   = 3'd0;
            state_d = StConvert;
        end else if (ena) begin
            if (state_q == StConvert) begin
                bcd_d = (bcd_adj << 1) | {11'd0, mag_q[7]};
                mag_d = mag_q << 1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = StShow;
                    frame_d = 3'd0;
                    tick_d  = '0;
                end
            end else if (state_q == StShow) begin
                if (tick_q == TickLast) begin
                    tick_d  = '0;
                    frame_d = (frame_q == 3'd4) ? 3'd0 : frame_q + 3'd1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            frame_q <= 3'd0;
            tick_q  <= '0;
            bcd_q   <= 12'd0;
            mag_q   <= 8'd0;
            cnt_q   <= 3'd0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            tick_q  <= tick_d;
            bcd_q   <= bcd_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end

    // Display decode of registered state; dark outside SHOW
    always_comb begin
        seg   = 7'h00;
        dp    = 1'b0;
        frame = 3'd0;
        if (state_q == StShow) begin
            frame = frame_q;
            case (frame_q)
                3'd0: seg = neg_q ? 7'h40 : 7'h00;
`ifdef ALU_DISP_LZB_EN
                3'd1: seg = (bcd_q[11:8] == 4'd0) ? 7'h00 : digit_seg(bcd_q[11:8]);
                3'd2: seg = (bcd_q[11:4] == 8'd0) ? 7'h00 : digit_seg(bcd_q[7:4]);
`else
                3'd1: seg = digit_seg(bcd_q[11:8]);
                3'd2: seg = digit_seg(bcd_q[7:4]);
`endif
                3'd3: begin
                    seg = digit_seg(bcd_q[3:0]);
                    dp  = 1'b1;
                end
                default: seg = 7'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_display.sv
// Directed self-checking bench for alu_result_display with DIGIT_TICKS=4.
module tb_alu_result_display;

    localparam int unsigned Ticks = 4;

`ifdef ALU_DISP_LZB_EN
    localparam logic [6:0] Lz = 7'h00;
`else
    localparam logic [6:0] Lz = 7'h3F;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] frame;

    int n_cmp = 0;
    int n_bad = 0;

    alu_result_display_if bus_if ();

    alu_result_display #(.DIGIT_TICKS(Ticks)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus_if),
        .seg   (seg),
        .dp    (dp),
        .frame (frame)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs and samples sit 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle accept pulse, then checks in_ready low for the full conversion
    task automatic send(input logic [7:0] d, input logic s, input string tag);
        bus_if.in_valid  = 1'b1;
        bus_if.in_data   = d;
        bus_if.in_signed = s;
        step();
        bus_if.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_eq({tag, " ready_conv"}, 32'(bus_if.in_ready), 32'd0);
            step();
        end
        check_eq({tag, " ready_show"}, 32'(bus_if.in_ready), 32'd1);
    endtask

    // Walk all five frames from frame 0 and check seg/dp/frame every cycle
    task automatic check_frames(input logic [6:0] f0, input logic [6:0] f1, input logic [6:0] f2,
                                input logic [6:0] f3, input string tag);
        logic [6:0] exp_seg [5];
        exp_seg = '{f0, f1, f2, f3, 7'h00};
        for (int f = 0; f < 5; f++) begin
            for (int t = 0; t < int'(Ticks); t++) begin
                check_eq({tag, " frame"}, 32'(frame), 32'(f));
                check_eq({tag, " seg"}, 32'(seg), 32'(exp_seg[f]));
                check_eq({tag, " dp"}, 32'(dp), (f == 3) ? 32'd1 : 32'd0);
                step();
            end
        end
        check_eq({tag, " wrap"}, 32'(frame), 32'd0);
        check_eq({tag, " wrap_seg"}, 32'(seg), 32'(f0));
    endtask

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = 8'h00;
        bus_if.in_signed = 1'b0;

        // Reset state
        #2;
        check_eq("rst ready", 32'(bus_if.in_ready), 32'd1);
        check_eq("rst seg", 32'(seg), 32'd0);
        check_eq("rst dp", 32'(dp), 32'd0);
        check_eq("rst frame", 32'(frame), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check_eq("idle ready", 32'(bus_if.in_ready), 32'd1);

        // Unsigned 255
        send(8'hFF, 1'b0, "u255");
        check_frames(7'h00, 7'h5B, 7'h6D, 7'h6D, "u255");

        // Signed -15
        send(8'hF1, 1'b1, "s-15");
        check_frames(7'h40, Lz, 7'h06, 7'h6D, "s-15");

        // Signed -128
        send(8'h80, 1'b1, "s-128");
        check_frames(7'h40, 7'h06, 7'h5B, 7'h7F, "s-128");

        // Asynchronous reset mid-SHOW, between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst seg", 32'(seg), 32'd0);
        check_eq("arst dp", 32'(dp), 32'd0);
        check_eq("arst frame", 32'(frame), 32'd0);
        check_eq("arst ready", 32'(bus_if.in_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        step();

        // Handshake: valid held through CONVERT with other data must be ignored
        bus_if.in_valid  = 1'b1;
        bus_if.in_data   = 8'd128;
        bus_if.in_signed = 1'b0;
        step();
        bus_if.in_data = 8'h55;
        for (int i = 0; i < 8; i++) begin
            check_eq("hs ready_conv", 32'(bus_if.in_ready), 32'd0);
            step();
        end
        bus_if.in_valid = 1'b0;
        check_eq("hs ready_show", 32'(bus_if.in_ready), 32'd1);
        check_frames(7'h00, 7'h06, 7'h5B, 7'h7F, "hs128");
        begin : wait_f2
            int guard = 0;
            while (frame != 3'd2 && guard < 40) begin
                step();
                guard++;
            end
            check_eq("hs reach_f2", 32'(frame), 32'd2);
        end
        send(8'd7, 1'b0, "hs7");
        check_frames(7'h00, Lz, Lz, 7'h07, "hs7");

        // ena low for 5 cycles during CONVERT stretches latency by exactly 5
        bus_if.in_valid  = 1'b1;
        bus_if.in_data   = 8'd200;
        bus_if.in_signed = 1'b0;
        step();
        bus_if.in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) ena = 1'b0;
            if (i == 8) ena = 1'b1;
            check_eq("ena ready_conv", 32'(bus_if.in_ready), 32'd0);
            step();
        end
        check_eq("ena frame_pre", 32'(frame), 32'd0);
        check_eq("ena ready_pre", 32'(bus_if.in_ready), 32'd0);
        step();
        check_eq("ena ready_show", 32'(bus_if.in_ready), 32'd1);
        check_frames(7'h00, 7'h5B, 7'h3F, 7'h3F, "ena200");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
